timer_tick_master: RTL and testbench

Hardware bus initiator for the system timer's 8-bit register interface. On a start request it programs prescaler, compare value and control over the timer's cs/read/write port. It then services each timer interrupt by reading STATUS and write-clearing the MATCH bit, maintaining a 32-bit system tick count and a divided scheduler tick. It sits between the timer and the task scheduler, so the CPU does not have to run an interrupt handler for every tick.

---
 rtl/timer_tick_master.sv | 225 ++++++++++++++++++++++
 tb/tb_timer_tick_master.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_tick_master.sv
// timer_tick_master
//
// Bus initiator for the system timer's 8-bit register port. A start request
// programs prescaler, compare value and control. After that the block
// services every timer interrupt: it reads STATUS and, on a real match,
// write-clears MATCH. It keeps a 32-bit tick count and a divided scheduler
// tick, so the CPU never has to take a per-tick interrupt.
//
// Request semantics: cfg_start and cfg_stop are level-sampled requests with
// no ready/acknowledge. A request is acted on only in a cycle where the
// current state accepts it (start: IDLE/RUN, stop: RUN). In any other state
// it is dropped, not held. Within RUN, stop wins over start, and start wins
// over timer_irq.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_start/cfg_stop  start / stop requests
//   cfg_prescale[7:0]   prescaler, captured on an accepted start
//   cfg_compare[15:0]   compare value, captured on an accepted start
//   cfg_mode            1 = continuous, 0 = one-shot, captured on start
//   bus_cs/read/write   timer port strobes, one cycle per access
//   bus_addr[2:0]       0 CTRL, 1 STATUS, 4 COMP_L, 5 COMP_H, 6 PRESCALE
//   bus_wdata[7:0]      write data
//   bus_rdata[7:0]      read data, combinational in the bus_read cycle
//   timer_irq           timer interrupt, level
//   tick_count[31:0]    serviced matches since the last accepted start
//   sched_tick          one-cycle pulse every TICK_DIV serviced matches
//   busy                high in INIT0..INIT5 and STOP
//   running             high in RUN, RD_STAT and CLR_STAT
//   dbg_state[3:0]      current FSM state encoding
module timer_tick_master #(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_start,
  input  logic        cfg_stop,
  input  logic [7:0]  cfg_prescale,
  input  logic [15:0] cfg_compare,
  input  logic        cfg_mode,
  output logic        bus_cs,
  output logic        bus_read,
  output logic        bus_write,
  output logic [2:0]  bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        timer_irq,
  output logic [31:0] tick_count,
  output logic        sched_tick,
  output logic        busy,
  output logic        running,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    INIT0    = 4'd1,
    INIT1    = 4'd2,
    INIT2    = 4'd3,
    INIT3    = 4'd4,
    INIT4    = 4'd5,
    INIT5    = 4'd6,
    RUN      = 4'd7,
    RD_STAT  = 4'd8,
    CLR_STAT = 4'd9,
    STOP     = 4'd10
  } state_e;

  localparam logic [2:0]  ADDR_CTRL     = 3'd0;
  localparam logic [2:0]  ADDR_STATUS   = 3'd1;
  localparam logic [2:0]  ADDR_COMP_L   = 3'd4;
  localparam logic [2:0]  ADDR_COMP_H   = 3'd5;
  localparam logic [2:0]  ADDR_PRESCALE = 3'd6;
  localparam logic [15:0] DIV_LAST      = 16'(TICK_DIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  prescale_q, prescale_d;
  logic [15:0] compare_q, compare_d;
  logic        mode_q, mode_d;
  logic [31:0] tick_count_q, tick_count_d;
  logic [15:0] div_q, div_d;
  logic        sched_q, sched_d;
  logic        cs_q, cs_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [2:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        running_q, running_d;

  logic        capture;
  logic        service;

  // Next-state and next-output logic. Bus strobes are decoded from the
  // *next* state so they are registered and appear in exactly the cycle the
  // FSM spends in the corresponding state.
  always_comb begin
    state_d      = state_q;
    capture      = 1'b0;
    service      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          capture = 1'b1;
          state_d = INIT0;
        end
      end
      INIT0: state_d = INIT1;
      INIT1: state_d = INIT2;
      INIT2: state_d = INIT3;
      INIT3: state_d = INIT4;
      INIT4: state_d = INIT5;
      INIT5: state_d = RUN;
      RUN: begin
        if (cfg_stop) begin
          state_d = STOP;
        end else if (cfg_start) begin
          capture = 1'b1;
          state_d = INIT0;
        end else if (timer_irq) begin
          state_d = RD_STAT;
        end
      end
      // A clear STATUS[0] means the irq was spurious: no write, no count.
      RD_STAT: state_d = bus_rdata[0] ? CLR_STAT : RUN;
      CLR_STAT: begin
        service = 1'b1;
        state_d = RUN;
      end
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Config used by the INIT writes must be the value being captured now,
    // because INIT0 is entered on the same edge as the capture.
    prescale_d = capture ? cfg_prescale : prescale_q;
    compare_d  = capture ? cfg_compare  : compare_q;
    mode_d     = capture ? cfg_mode     : mode_q;

    tick_count_d = tick_count_q;
    div_d        = div_q;
    sched_d      = 1'b0;
    if (capture) begin
      tick_count_d = 32'd0;
      div_d        = 16'd0;
    end else if (service) begin
      tick_count_d = tick_count_q + 32'd1;
      if (div_q == DIV_LAST) begin
        div_d   = 16'd0;
        sched_d = 1'b1;
      end else begin
        div_d = div_q + 16'd1;
      end
    end

    cs_d    = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = 3'd0;
    wdata_d = 8'h00;
    unique case (state_d)
      INIT0:    begin cs_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_CTRL;     wdata_d = 8'h08;             end
      INIT1:    begin cs_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_PRESCALE; wdata_d = prescale_d;        end
      INIT2:    begin cs_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_COMP_L;   wdata_d = compare_d[7:0];    end
      INIT3:    begin cs_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_COMP_H;   wdata_d = compare_d[15:8];   end
      INIT4:    begin cs_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_STATUS;   wdata_d = 8'h01;             end
      // CTRL = enable | irq enable | (continuous << 1)
      INIT5:    begin cs_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_CTRL;     wdata_d = {5'b00001, mode_d, 1'b1}; end
      RD_STAT:  begin cs_d = 1'b1; rd_d = 1'b1; addr_d = ADDR_STATUS;   wdata_d = 8'h00;             end
      CLR_STAT: begin cs_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_STATUS;   wdata_d = 8'h01;             end
      STOP:     begin cs_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_CTRL;     wdata_d = 8'h00;             end
      default:  begin cs_d = 1'b0; end
    endcase

    busy_d    = (state_d inside {INIT0, INIT1, INIT2, INIT3, INIT4, INIT5, STOP});
    running_d = (state_d inside {RUN, RD_STAT, CLR_STAT});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prescale_q   <= 8'h00;
      compare_q    <= 16'h0000;
      mode_q       <= 1'b0;
      tick_count_q <= 32'd0;
      div_q        <= 16'd0;
      sched_q      <= 1'b0;
      cs_q         <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= 3'd0;
      wdata_q      <= 8'h00;
      busy_q       <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prescale_q   <= prescale_d;
      compare_q    <= compare_d;
      mode_q       <= mode_d;
      tick_count_q <= tick_count_d;
      div_q        <= div_d;
      sched_q      <= sched_d;
      cs_q         <= cs_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
      running_q    <= running_d;
    end
  end

  assign bus_cs     = cs_q;
  assign bus_read   = rd_q;
  assign bus_write  = wr_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign tick_count = tick_count_q;
  assign sched_tick = sched_q;
  assign busy       = busy_q;
  assign running    = running_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_timer_tick_master.sv
// Bench for timer_tick_master: a small behavioural timer on the register
// port, an override path for irq/rdata, a bus scoreboard, and directed
// stimulus for init, service, spurious irq, wrap, stop/start collisions and
// reset in the middle of a service.
module tb_timer_tick_master;

  localparam int TICK_DIV = 3;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_INIT2 = 4'd3;
  localparam logic [3:0] S_RUN   = 4'd7;
  localparam logic [3:0] S_CLR   = 4'd9;
  localparam logic [3:0] S_STOP  = 4'd10;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        cfg_start = 1'b0;
  logic        cfg_stop = 1'b0;
  logic [7:0]  cfg_prescale = 8'h00;
  logic [15:0] cfg_compare = 16'h0000;
  logic        cfg_mode = 1'b0;
  logic        bus_cs, bus_read, bus_write;
  logic [2:0]  bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        timer_irq;
  logic [31:0] tick_count;
  logic        sched_tick, busy, running;
  logic [3:0]  dbg_state;

  timer_tick_master #(.TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_prescale(cfg_prescale), .cfg_compare(cfg_compare), .cfg_mode(cfg_mode),
    .bus_cs(bus_cs), .bus_read(bus_read), .bus_write(bus_write),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .timer_irq(timer_irq), .tick_count(tick_count), .sched_tick(sched_tick),
    .busy(busy), .running(running), .dbg_state(dbg_state)
  );

  // scoreboard state: {read, write, addr, wdata}
  logic [12:0] exp_q[$];
  int n_pass = 0;
  int n_total = 0;
  int sched_cnt = 0;

  function automatic logic [12:0] bx(input logic rd, input logic wr,
                                     input logic [2:0] a, input logic [7:0] d);
    return {rd, wr, a, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // behavioural timer
  logic [7:0]  tm_ctrl, tm_status, tm_pre, tm_comp_l, tm_comp_h, tm_precnt;
  logic [15:0] tm_cnt;
  int          tm_matches = 0;
  bit          pred_en = 1'b0;
  bit          ovr_en = 1'b0;
  logic        ovr_irq = 1'b0;
  logic [7:0]  ovr_rdata = 8'h00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tm_ctrl <= 8'h00; tm_status <= 8'h00; tm_pre <= 8'h00;
      tm_comp_l <= 8'h00; tm_comp_h <= 8'h00; tm_precnt <= 8'h00; tm_cnt <= 16'h0;
    end else begin
      if (tm_ctrl[0]) begin
        if (tm_precnt == tm_pre) begin
          tm_precnt <= 8'h00;
          if (tm_cnt == {tm_comp_h, tm_comp_l}) begin
            tm_cnt <= 16'h0;
            tm_status[0] <= 1'b1;
            tm_matches <= tm_matches + 1;
            if (!tm_ctrl[1]) tm_ctrl[0] <= 1'b0;
            if (pred_en) begin
              exp_q.push_back(bx(1'b1, 1'b0, 3'd1, 8'h00));
              exp_q.push_back(bx(1'b0, 1'b1, 3'd1, 8'h01));
            end
          end else begin
            tm_cnt <= tm_cnt + 16'd1;
          end
        end else begin
          tm_precnt <= tm_precnt + 8'd1;
        end
      end
      if (bus_cs && bus_write) begin
        case (bus_addr)
          3'd0: begin
            tm_ctrl <= bus_wdata;
            if (bus_wdata[3]) begin tm_cnt <= 16'h0; tm_precnt <= 8'h00; end
          end
          3'd1: if (bus_wdata[0]) tm_status[0] <= 1'b0;
          3'd4: tm_comp_l <= bus_wdata;
          3'd5: tm_comp_h <= bus_wdata;
          3'd6: tm_pre <= bus_wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus_rdata = 8'h00;
    if (bus_read) begin
      if (ovr_en) bus_rdata = ovr_rdata;
      else if (bus_addr == 3'd1) bus_rdata = tm_status;
      else if (bus_addr == 3'd0) bus_rdata = tm_ctrl;
    end
    timer_irq = ovr_en ? ovr_irq : (tm_status[0] & tm_ctrl[2]);
  end

  // monitor: compares every bus access against the expected queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_cs) begin
        if (exp_q.size() == 0) begin
          chk("bus_unexpected", {19'd0, bus_read, bus_write, bus_addr, bus_wdata}, 32'h1FFF);
        end else begin
          chk("bus_txn", {19'd0, bus_read, bus_write, bus_addr, bus_wdata}, {19'd0, exp_q.pop_front()});
        end
      end else begin
        chk("bus_idle", {19'd0, bus_read, bus_write, bus_addr, bus_wdata}, 32'd0);
      end
      if (sched_tick) sched_cnt++;
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Pulses an accepted start; returns in cycle 1 (INIT0).
  task automatic do_start(input logic [7:0] pre, input logic [15:0] cmp, input logic mode);
    exp_q.push_back(bx(1'b0, 1'b1, 3'd0, 8'h08));
    exp_q.push_back(bx(1'b0, 1'b1, 3'd6, pre));
    exp_q.push_back(bx(1'b0, 1'b1, 3'd4, cmp[7:0]));
    exp_q.push_back(bx(1'b0, 1'b1, 3'd5, cmp[15:8]));
    exp_q.push_back(bx(1'b0, 1'b1, 3'd1, 8'h01));
    exp_q.push_back(bx(1'b0, 1'b1, 3'd0, mode ? 8'h07 : 8'h05));
    @(posedge clk); #1;
    cfg_prescale = pre; cfg_compare = cmp; cfg_mode = mode; cfg_start = 1'b1;
    step(1);
    cfg_start = 1'b0;
  endtask

  // Overridden irq with MATCH set; checks count and sched_tick in cycle E+3.
  task automatic service(input logic [31:0] exp_tick, input logic exp_sched);
    exp_q.push_back(bx(1'b1, 1'b0, 3'd1, 8'h00));
    exp_q.push_back(bx(1'b0, 1'b1, 3'd1, 8'h01));
    ovr_irq = 1'b1; ovr_rdata = 8'h01;
    step(1);
    ovr_irq = 1'b0;
    step(2);
    chk("svc_tick", tick_count, exp_tick);
    chk("svc_sched", {31'd0, sched_tick}, {31'd0, exp_sched});
    step(1);
  endtask

  task automatic wait_match(output bit ok);
    int m0;
    m0 = tm_matches;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (tm_matches != m0) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, svc, sched_base;
    bit ok;

    // reset
    #1 rst_n = 1'b0;
    #10;
    chk("rst_bus", {19'd0, bus_cs, bus_read, bus_write, bus_addr, bus_wdata}, 32'd0);
    chk("rst_tick", tick_count, 32'd0);
    chk("rst_flags", {28'd0, sched_tick, busy, running, 1'b0}, 32'd0);
    chk("rst_state", {28'd0, dbg_state}, {28'd0, S_IDLE});
    @(posedge clk); #1 rst_n = 1'b1;

    // init sequence timing
    do_start(8'h03, 16'h0010, 1'b1);
    chk("init_busy_c1", {31'd0, busy}, 32'd1);
    chk("init_run_c1", {31'd0, running}, 32'd0);
    step(5);
    chk("init_run_c6", {31'd0, running}, 32'd0);
    step(1);
    chk("init_run_c7", {31'd0, running}, 32'd1);
    chk("init_busy_c7", {31'd0, busy}, 32'd0);
    exp_q.push_back(bx(1'b0, 1'b1, 3'd0, 8'h00));
    cfg_stop = 1'b1;
    step(1);
    cfg_stop = 1'b0;
    chk("stop_busy", {31'd0, busy}, 32'd1);
    step(1);
    chk("stop_idle", {28'd0, dbg_state}, {28'd0, S_IDLE});

    // continuous service against the behavioural timer
    base = tm_matches;
    sched_base = sched_cnt;
    pred_en = 1'b1;
    do_start(8'h00, 16'h0004, 1'b1);
    for (int k = 0; k < 30; k++) begin
      wait_match(ok);
      chk("match_seen", {31'd0, ok}, 32'd1);
      step(4);
      chk("cont_tick", tick_count, 32'(tm_matches - base));
      chk("cont_sched", 32'(sched_cnt - sched_base), 32'((tm_matches - base) / TICK_DIV));
    end
    svc = tm_matches - base;
    pred_en = 1'b0;
    ovr_en = 1'b1;

    // spurious irq
    exp_q.push_back(bx(1'b1, 1'b0, 3'd1, 8'h00));
    ovr_irq = 1'b1; ovr_rdata = 8'h02;
    step(1);
    ovr_irq = 1'b0;
    step(3);
    chk("spur_tick", tick_count, 32'(svc));
    chk("spur_state", {28'd0, dbg_state}, {28'd0, S_RUN});

    // wrap-around
    force dut.tick_count_q = 32'hFFFF_FFFF;
    step(1);
    release dut.tick_count_q;
    chk("wrap_pre", tick_count, 32'hFFFF_FFFF);
    svc++;
    service(32'h0000_0000, (svc % TICK_DIV) == 0);
    svc++;
    service(32'h0000_0001, (svc % TICK_DIV) == 0);

    // stop and irq in the same RUN cycle
    exp_q.push_back(bx(1'b0, 1'b1, 3'd0, 8'h00));
    cfg_stop = 1'b1; ovr_irq = 1'b1; ovr_rdata = 8'h01;
    step(1);
    cfg_stop = 1'b0; ovr_irq = 1'b0;
    chk("coll_stop_state", {28'd0, dbg_state}, {28'd0, S_STOP});
    chk("coll_running", {31'd0, running}, 32'd0);
    step(1);
    chk("coll_idle", {28'd0, dbg_state}, {28'd0, S_IDLE});
    chk("coll_tick_held", tick_count, 32'd1);

    // stop and irq are ignored in IDLE
    cfg_stop = 1'b1; ovr_irq = 1'b1;
    step(1);
    cfg_stop = 1'b0; ovr_irq = 1'b0;
    step(1);
    chk("idle_ignore", {28'd0, dbg_state}, {28'd0, S_IDLE});

    // restart; a start pulse in INIT2 must be dropped
    do_start(8'h11, 16'hABCD, 1'b0);
    chk("restart_tick_clr", tick_count, 32'd0);
    step(2);
    chk("restart_init2", {28'd0, dbg_state}, {28'd0, S_INIT2});
    cfg_prescale = 8'h55; cfg_compare = 16'h1234; cfg_mode = 1'b1; cfg_start = 1'b1;
    step(1);
    cfg_start = 1'b0;
    step(3);
    chk("restart_run_c7", {31'd0, running}, 32'd1);

    // reset during CLR_STAT
    exp_q.push_back(bx(1'b1, 1'b0, 3'd1, 8'h00));
    ovr_irq = 1'b1; ovr_rdata = 8'h01;
    step(1);
    ovr_irq = 1'b0;
    step(1);
    chk("midrst_in_clr", {28'd0, dbg_state}, {28'd0, S_CLR});
    rst_n = 1'b0;
    #1;
    chk("midrst_bus", {19'd0, bus_cs, bus_read, bus_write, bus_addr, bus_wdata}, 32'd0);
    chk("midrst_tick", tick_count, 32'd0);
    chk("midrst_flags", {29'd0, sched_tick, busy, running}, 32'd0);
    chk("midrst_state", {28'd0, dbg_state}, {28'd0, S_IDLE});
    @(posedge clk); #1 rst_n = 1'b1;
    do_start(8'h03, 16'h0010, 1'b1);
    step(6);
    chk("rerun_c7", {31'd0, running}, 32'd1);

    step(3);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
